wb_slave_regfile: RTL and testbench

Synthesizable Wishbone classic-cycle slave: the responder end of the Wishbone master bus-functional interface used by our I2C testbench. It holds a small register file with a programmable number of wait states and a write-triggered interrupt. It serves as a known-good target for self-checking the Wishbone master agent, and for exercising its ack-wait and interrupt-wait paths before the agent is pointed at the I2C DUT.

---
 rtl/wb_slave_regfile.sv | 135 +++++++++++++
 tb/tb_wb_slave_regfile.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/wb_slave_regfile.sv
// Wishbone classic-cycle slave with a small register file, programmable wait states
// and a write-triggered level interrupt (R0[0] enables, the top register raises it).
module wb_slave_regfile #(
  parameter int unsigned ADDR_WIDTH  = 2,
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cyc_i,
  input  logic                  stb_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] adr_i,
  input  logic [DATA_WIDTH-1:0] dat_i,
  output logic                  ack_o,
  output logic [DATA_WIDTH-1:0] dat_o,
  output logic                  irq_o
);

  localparam int unsigned NREGS = 2 ** ADDR_WIDTH;
  localparam int unsigned CNT_W = 4;
  localparam logic [ADDR_WIDTH-1:0] IRQ_IDX = '1;
  localparam logic [ADDR_WIDTH-1:0] EN_IDX  = '0;
  localparam logic [CNT_W-1:0] CNT_INIT =
    (WAIT_STATES == 0) ? '0 : CNT_W'(WAIT_STATES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACK  = 2'd2
  } state_e;

  state_e                  state_q;
  logic [CNT_W-1:0]        cnt_q;
  logic                    ack_q;
  logic [DATA_WIDTH-1:0]   dat_q;
  logic                    rd_irq_q;
  logic [DATA_WIDTH-1:0]   regs_q [NREGS];
  logic                    pend_q;
  logic                    irq_q;

  logic req;
  logic enter_ack;
  logic wr_commit;
  logic pend_d;
  logic en_d;

  // Transfer qualification and the post-edge values that drive the interrupt flop
  always_comb begin
    req       = cyc_i & stb_i;
    enter_ack = 1'b0;
    wr_commit = 1'b0;
    pend_d    = pend_q;
    en_d      = regs_q[EN_IDX][0];

    if (req) begin
      if (state_q == S_IDLE && WAIT_STATES == 0) enter_ack = 1'b1;
      if (state_q == S_WAIT && cnt_q == '0)      enter_ack = 1'b1;
    end

    wr_commit = (state_q == S_ACK) & req & we_i;

    if (wr_commit && adr_i == IRQ_IDX) begin
      pend_d = 1'b1;
    end else if (state_q == S_ACK && rd_irq_q) begin
      pend_d = 1'b0;
    end

    if (wr_commit && adr_i == EN_IDX) en_d = dat_i[0];
  end

  // Bus state machine with registered ack and read data
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      ack_q    <= 1'b0;
      dat_q    <= '0;
      rd_irq_q <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      dat_q <= '0;

      if (enter_ack) begin
        state_q  <= S_ACK;
        ack_q    <= 1'b1;
        dat_q    <= regs_q[adr_i];
        rd_irq_q <= ~we_i & (adr_i == IRQ_IDX);
      end else begin
        case (state_q)
          S_IDLE: begin
            if (req) begin
              state_q <= S_WAIT;
              cnt_q   <= CNT_INIT;
            end
          end
          S_WAIT: begin
            if (!req) state_q <= S_IDLE;
            else      cnt_q   <= cnt_q - CNT_W'(1);
          end
          S_ACK: begin
            state_q  <= S_IDLE;
            rd_irq_q <= 1'b0;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  // Register file; writes land at the edge closing the ack cycle
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < int'(NREGS); i++) regs_q[i] <= '0;
    end else if (wr_commit) begin
      regs_q[adr_i] <= dat_i;
    end
  end

  // Interrupt pending flag; irq flop tracks pending & enable as they will be after this edge
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      pend_q <= 1'b0;
      irq_q  <= 1'b0;
    end else begin
      pend_q <= pend_d;
      irq_q  <= pend_d & en_d;
    end
  end

  assign ack_o = ack_q;
  assign dat_o = dat_q;
  assign irq_o = irq_q;

endmodule

// File: tb/tb_wb_slave_regfile.sv
// Scoreboarded bench for wb_slave_regfile: three instances (1, 0 and 3 wait states)
// driven by a Wishbone master task and checked against an array-based register model.
module tb_wb_slave_regfile;

  typedef struct {
    bit          rd;
    logic [7:0]  data;
    int unsigned cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] cyc, stb, ack, irq;
  logic       we;
  logic [1:0] adr;
  logic [7:0] wdat;
  logic [7:0] rdat [3];

  int          checks = 0;
  int          errors = 0;
  int unsigned cyc_cnt = 0;

  logic [7:0] mregs [3][4];
  bit         mpend [3];
  exp_t       exp_q [3][$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  wb_slave_regfile #(.ADDR_WIDTH(2), .DATA_WIDTH(8), .WAIT_STATES(1)) u_ws1 (
    .clk_i(clk), .rst_i(rst_n), .cyc_i(cyc[0]), .stb_i(stb[0]), .we_i(we),
    .adr_i(adr), .dat_i(wdat), .ack_o(ack[0]), .dat_o(rdat[0]), .irq_o(irq[0]));
  wb_slave_regfile #(.ADDR_WIDTH(2), .DATA_WIDTH(8), .WAIT_STATES(0)) u_ws0 (
    .clk_i(clk), .rst_i(rst_n), .cyc_i(cyc[1]), .stb_i(stb[1]), .we_i(we),
    .adr_i(adr), .dat_i(wdat), .ack_o(ack[1]), .dat_o(rdat[1]), .irq_o(irq[1]));
  wb_slave_regfile #(.ADDR_WIDTH(2), .DATA_WIDTH(8), .WAIT_STATES(3)) u_ws3 (
    .clk_i(clk), .rst_i(rst_n), .cyc_i(cyc[2]), .stb_i(stb[2]), .we_i(we),
    .adr_i(adr), .dat_i(wdat), .ack_o(ack[2]), .dat_o(rdat[2]), .irq_o(irq[2]));

  function automatic int unsigned ws_of(input int d);
    case (d)
      0:       return 1;
      1:       return 0;
      default: return 3;
    endcase
  endfunction

  function automatic bit model_irq(input int d);
    return mpend[d] & mregs[d][0][0];
  endfunction

  task automatic check(input bit ok, input string name, input int act, input int req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      mpend[d] = 1'b0;
      for (int r = 0; r < 4; r++) mregs[d][r] = 8'h00;
    end
  endtask

  // Monitor: pops the expected response whenever a DUT acks
  for (genvar g = 0; g < 3; g++) begin : g_mon
    always @(negedge clk) begin
      exp_t e;
      if (rst_n) begin
        if (ack[g]) begin
          if (exp_q[g].size() == 0) begin
            check(1'b0, $sformatf("spurious_ack_dut%0d", g), 1, 0);
          end else begin
            e = exp_q[g].pop_front();
            check(e.cyc == cyc_cnt, $sformatf("ack_cycle_dut%0d", g), int'(cyc_cnt), int'(e.cyc));
            if (e.rd)
              check(rdat[g] === e.data, $sformatf("read_data_dut%0d", g), int'(rdat[g]), int'(e.data));
          end
        end else begin
          check(rdat[g] === 8'h00, $sformatf("dat_idle_dut%0d", g), int'(rdat[g]), 0);
        end
      end
    end
  end

  // Master transfer; called and returns at a falling edge
  task automatic xfer(input int d, input bit w, input int a, input logic [7:0] wd);
    exp_t e;
    bit   old_irq;
    bit   done;
    old_irq = model_irq(d);
    e.rd    = !w;
    e.cyc   = cyc_cnt + 1 + ws_of(d);
    e.data  = 8'h00;
    if (w) begin
      mregs[d][a] = wd;
      if (a == 3) mpend[d] = 1'b1;
    end else begin
      e.data = mregs[d][a];
      if (a == 3) mpend[d] = 1'b0;
    end
    exp_q[d].push_back(e);
    cyc[d] = 1'b1; stb[d] = 1'b1; we = w; adr = 2'(a); wdat = wd;
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (ack[d]) done = 1'b1;
    end
    check(done, $sformatf("ack_timeout_dut%0d", d), int'(done), 1);
    if (!done) begin
      void'(exp_q[d].pop_back());
      cyc[d] = 1'b0; stb[d] = 1'b0;
      return;
    end
    check(irq[d] === old_irq, $sformatf("irq_during_ack_dut%0d", d), int'(irq[d]), int'(old_irq));
    @(negedge clk);
    cyc[d] = 1'b0; stb[d] = 1'b0;
    check(irq[d] === model_irq(d), $sformatf("irq_after_ack_dut%0d", d), int'(irq[d]), int'(model_irq(d)));
  endtask

  task automatic wait_irq(input int d, input int budget, output int waited);
    waited = 0;
    while (irq[d] !== 1'b1 && waited < budget) begin
      @(negedge clk);
      waited++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int waited;
    rst_n = 1'b0; cyc = '0; stb = '0; we = 1'b0; adr = '0; wdat = '0;
    model_reset();
    #12;
    for (int d = 0; d < 3; d++) begin
      check(ack[d] === 1'b0, "reset_ack", int'(ack[d]), 0);
      check(rdat[d] === 8'h00, "reset_dat", int'(rdat[d]), 0);
      check(irq[d] === 1'b0, "reset_irq", int'(irq[d]), 0);
    end
    #11 rst_n = 1'b1;
    @(negedge clk);

    // One wait state: write/read R1, R2 untouched
    xfer(0, 1'b1, 1, 8'hA5);
    xfer(0, 1'b0, 1, 8'h00);
    xfer(0, 1'b0, 2, 8'h00);

    // Zero wait states, back-to-back
    xfer(1, 1'b1, 0, 8'h11);
    xfer(1, 1'b1, 1, 8'h22);
    xfer(1, 1'b1, 2, 8'h33);
    xfer(1, 1'b1, 3, 8'h44);
    for (int r = 0; r < 4; r++) xfer(1, 1'b0, r, 8'h00);

    // Interrupt enable / raise / mask / clear
    xfer(0, 1'b1, 0, 8'h01);
    xfer(0, 1'b1, 3, 8'h5A);
    check(irq[0] === 1'b1, "irq_raised", int'(irq[0]), 1);
    xfer(0, 1'b1, 0, 8'h00);
    check(irq[0] === 1'b0, "irq_masked", int'(irq[0]), 0);
    xfer(0, 1'b1, 0, 8'h01);
    wait_irq(0, 20, waited);
    check(waited == 0, "irq_wait_prompt", waited, 0);
    xfer(0, 1'b0, 3, 8'h00);
    check(irq[0] === 1'b0, "irq_cleared", int'(irq[0]), 0);
    xfer(0, 1'b1, 3, 8'h66);

    // Abort during wait states: no ack, no write
    xfer(2, 1'b1, 2, 8'h3C);
    cyc[2] = 1'b1; stb[2] = 1'b1; we = 1'b1; adr = 2'd2; wdat = 8'hFF;
    @(negedge clk);
    cyc[2] = 1'b0; stb[2] = 1'b0;
    repeat (6) @(negedge clk);
    xfer(2, 1'b0, 2, 8'h00);

    // Asynchronous reset in the middle of a waiting write
    check(irq[0] === 1'b1, "irq_before_reset", int'(irq[0]), 1);
    cyc[2] = 1'b1; stb[2] = 1'b1; we = 1'b1; adr = 2'd1; wdat = 8'h77;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) begin
      check(ack[d] === 1'b0, "midreset_ack", int'(ack[d]), 0);
      check(rdat[d] === 8'h00, "midreset_dat", int'(rdat[d]), 0);
      check(irq[d] === 1'b0, "midreset_irq", int'(irq[d]), 0);
    end
    cyc[2] = 1'b0; stb[2] = 1'b0;
    model_reset();
    @(posedge clk); @(posedge clk);
    #3 rst_n = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 3; d++)
      for (int r = 0; r < 4; r++) xfer(d, 1'b0, r, 8'h00);
    xfer(2, 1'b1, 1, 8'h5C);
    xfer(2, 1'b0, 1, 8'h00);

    // Randomized traffic against the model
    for (int n = 0; n < 80; n++) begin
      int d;
      d = int'($urandom_range(0, 2));
      xfer(d, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), 8'($urandom));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (5) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      check(exp_q[d].size() == 0, "outstanding_acks", exp_q[d].size(), 0);
      check(irq[d] === model_irq(d), "final_irq", int'(irq[d]), int'(model_irq(d)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
